// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback controller and its arbiter.
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    typedef logic [4:0] regnum_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } wbc_state_e;

    // Requester ids double as bit positions in the arbiter request/grant vectors.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_ctrl_wb_arb2.sv
// Two-way writeback arbiter: MEM-over-ALU fixed priority, or round-robin when
// WB_ARB_RR_EN is defined. Grant is combinational from requests and pointer.
module wb_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef WB_ARB_RR_EN
    // Last granted requester; reset to ALU so MEM is favoured first.
    wb_src_e last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= SRC_ALU;
        end else if (|gnt) begin
            last_q <= gnt[SRC_MEM] ? SRC_MEM : SRC_ALU;
        end
    end

    always_comb begin
        gnt = '0;
        if (req[SRC_MEM] && (!req[SRC_ALU] || last_q == SRC_ALU)) begin
            gnt[SRC_MEM] = 1'b1;
        end else if (req[SRC_ALU]) begin
            gnt[SRC_ALU] = 1'b1;
        end
    end
`else
    // Fixed priority keeps no state, so the clock and reset go unused here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        gnt = '0;
        if (req[SRC_MEM]) begin
            gnt[SRC_MEM] = 1'b1;
        end else if (req[SRC_ALU]) begin
            gnt[SRC_ALU] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller with RAW/WAW scoreboard and halt drain.
// Arbitration is round-robin when WB_ARB_RR_EN is defined, else MEM-first.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic            issue_we,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      issue_rs,
    input  logic [4:0]      issue_rt,
    output logic            issue_ok,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            rd_we,
    output logic [4:0]      rd_num,
    output logic [XLEN-1:0] rd_data,
    input  logic            halt_req,
    output logic            halted
);

    wbc_state_e      state_q, state_d;
    logic [NREG-1:0] pending_q, pending_d;
    logic [1:0]      req, gnt;
    logic            issue_fire;
    logic            drain_done;
    regnum_t         sel_rd;
    logic [XLEN-1:0] sel_data;

    // A halted controller stops accepting writebacks entirely.
    assign req[SRC_ALU] = alu_valid & (state_q != HALTED);
    assign req[SRC_MEM] = mem_valid & (state_q != HALTED);

    wb_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu_ready = gnt[SRC_ALU];
    assign mem_ready = gnt[SRC_MEM];
    assign sel_rd    = gnt[SRC_MEM] ? mem_rd   : alu_rd;
    assign sel_data  = gnt[SRC_MEM] ? mem_data : alu_data;

    assign issue_ok = (state_q == RUN) & ~pending_q[issue_rs] & ~pending_q[issue_rt]
                    & ~(issue_we & pending_q[issue_rd]);
    assign issue_fire = issue_valid & issue_ok & issue_we & (issue_rd != '0);

    assign drain_done = (pending_q == '0) & ~alu_valid & ~mem_valid & ~rd_we;

    // NOTE: every variable gets its default first, so no path can infer a latch.
    always_comb begin
        pending_d = pending_q;
        if (rd_we) begin
            pending_d[rd_num] = 1'b0;
        end
        // Applied after the clear so a same-cycle re-issue keeps the bit set.
        if (issue_fire) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_req)   state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pending_q <= '0;
            rd_we     <= 1'b0;
            rd_num    <= '0;
            rd_data   <= '0;
            halted    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            halted    <= (state_d == HALTED);
            // A granted write to r0 is consumed without touching the file.
            rd_we     <= (|gnt) & (sel_rd != '0);
            if (|gnt) begin
                rd_num  <= sel_rd;
                rd_data <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed vector table, then random
// traffic checked against a behavioural scoreboard/drain model.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid = 1'b0, issue_we = 1'b0;
    logic [4:0]  issue_rd = '0, issue_rs = '0, issue_rt = '0;
    logic        issue_ok;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_rd = '0, mem_rd = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        alu_ready, mem_ready;
    logic        rd_we;
    logic [4:0]  rd_num;
    logic [31:0] rd_data;
    logic        halt_req = 1'b0;
    logic        halted;

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .issue_rs(issue_rs), .issue_rt(issue_rt), .issue_ok(issue_ok),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rd_we(rd_we), .rd_num(rd_num), .rd_data(rd_data),
        .halt_req(halt_req), .halted(halted)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs: rst iv iwe ird irs irt | av ard ad | mv mrd md | halt
    // Expected: ok ar mr we num data halted (num/data compared only when we=1)
    typedef struct {
        logic [31:0] rst, iv, iwe, ird, irs, irt;
        logic [31:0] av, ard, ad, mv, mrd, md, halt;
        logic [31:0] ok, ar, mr, we, num, data, hlt;
    } vec_t;

    vec_t tv[$];

    task automatic apply(input vec_t v);
        rst         = v.rst[0];
        issue_valid = v.iv[0];
        issue_we    = v.iwe[0];
        issue_rd    = v.ird[4:0];
        issue_rs    = v.irs[4:0];
        issue_rt    = v.irt[4:0];
        alu_valid   = v.av[0];
        alu_rd      = v.ard[4:0];
        alu_data    = v.ad;
        mem_valid   = v.mv[0];
        mem_rd      = v.mrd[4:0];
        mem_data    = v.md;
        halt_req    = v.halt[0];
    endtask

    // Behavioural model state (0=running, 1=draining, 2=halted)
    bit [31:0] m_pend;
    int        m_state;
    bit        m_we, m_halted, m_mem_fav;
    bit [4:0]  m_num;
    bit [31:0] m_data;

    // Random requesters
    bit        a_v, q_v, a_acc, q_acc;
    bit [4:0]  a_rd, q_rd;
    bit [31:0] a_d, q_d;

    function automatic int pick_pending(input bit [31:0] p);
        int s;
        s = int'($urandom_range(0, 31));
        for (int k = 0; k < 32; k++) begin
            if (p[(s + k) % 32]) return (s + k) % 32;
        end
        return -1;
    endfunction

    function automatic int new_rd();
        if (m_state == 0) begin
            if ($urandom_range(0, 1) == 1 && m_pend != 0) return pick_pending(m_pend);
            return int'($urandom_range(0, 7));
        end
        return (m_pend != 0) ? pick_pending(m_pend) : -1;
    endfunction

    int  r, st_cnt;
    bit  e_ok, ga, gq, done;

    initial begin
        tv.push_back('{0,1,1,5,0,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});
        tv.push_back('{0,1,0,0,5,0, 1,5,32'hDEADBEEF,0,0,0,    0, 0,1,0,0,0,0,0});
        tv.push_back('{0,1,0,0,5,0, 0,0,0,          0,0,0,    0, 0,0,0,1,5,32'hDEADBEEF,0});
        tv.push_back('{0,1,0,0,5,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,3,32'h11,     1,4,32'h22,0, 1,0,1,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,3,32'h11,     0,0,0,    0, 1,1,0,1,4,32'h22,0});
        tv.push_back('{0,0,0,0,0,0, 0,0,0,          0,0,0,    0, 1,0,0,1,3,32'h11,0});
        tv.push_back('{0,0,0,0,0,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,0,32'hFFFFFFFF,0,0,0,    0, 1,1,0,0,0,0,0});
        tv.push_back('{0,1,1,0,0,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});
        tv.push_back('{0,1,1,0,0,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,7,32'h77,     0,0,0,    0, 1,1,0,0,0,0,0});
        tv.push_back('{0,1,1,7,0,0, 0,0,0,          0,0,0,    0, 1,0,0,1,7,32'h77,0});
        tv.push_back('{0,1,0,0,7,0, 0,0,0,          0,0,0,    0, 0,0,0,0,0,0,0});
        tv.push_back('{0,1,0,0,7,0, 1,7,32'h70,     0,0,0,    0, 0,1,0,0,0,0,0});
        tv.push_back('{0,1,0,0,7,0, 0,0,0,          0,0,0,    0, 0,0,0,1,7,32'h70,0});
        tv.push_back('{0,1,0,0,7,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});
        tv.push_back('{0,1,1,9,0,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 0,0,0,          0,0,0,    1, 1,0,0,0,0,0,0});
        tv.push_back('{0,1,0,0,0,0, 0,0,0,          0,0,0,    0, 0,0,0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 0,0,0,          1,9,32'h99,0, 0,0,1,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 0,0,0,          0,0,0,    0, 0,0,0,1,9,32'h99,0});
        tv.push_back('{0,0,0,0,0,0, 0,0,0,          0,0,0,    0, 0,0,0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 1,1,32'h5,      0,0,0,    0, 0,0,0,0,0,0,1});
        tv.push_back('{0,0,0,0,0,0, 1,1,32'h5,      0,0,0,    0, 0,0,0,0,0,0,1});
        tv.push_back('{1,0,0,0,0,0, 0,0,0,          0,0,0,    0, 0,0,0,0,0,0,1});
        tv.push_back('{0,1,1,2,0,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 0,0,0,          0,0,0,    1, 1,0,0,0,0,0,0});
        tv.push_back('{1,1,0,0,2,0, 0,0,0,          0,0,0,    0, 0,0,0,0,0,0,0});
        tv.push_back('{0,1,1,2,2,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});
        tv.push_back('{0,0,0,0,0,0, 0,0,0,          0,0,0,    0, 1,0,0,0,0,0,0});

        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            apply(tv[i]);
            #1;
            check($sformatf("t%0d issue_ok", i),  32'(issue_ok),  tv[i].ok);
            check($sformatf("t%0d alu_ready", i), 32'(alu_ready), tv[i].ar);
            check($sformatf("t%0d mem_ready", i), 32'(mem_ready), tv[i].mr);
            check($sformatf("t%0d rd_we", i),     32'(rd_we),     tv[i].we);
            check($sformatf("t%0d halted", i),    32'(halted),    tv[i].hlt);
            if (tv[i].we[0]) begin
                check($sformatf("t%0d rd_num", i),  32'(rd_num), tv[i].num);
                check($sformatf("t%0d rd_data", i), rd_data,     tv[i].data);
            end
        end

        // Random traffic from a clean reset.
        @(negedge clk);
        rst = 1'b1; issue_valid = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        m_pend = '0; m_state = 0; m_we = 0; m_num = '0; m_data = '0;
        m_halted = 0; m_mem_fav = 1;
        a_v = 0; q_v = 0; a_acc = 0; q_acc = 0; st_cnt = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (a_acc) a_v = 0;
            if (q_acc) q_v = 0;
            if (m_state != 2 && !a_v && $urandom_range(0, 2) == 0) begin
                r = new_rd();
                if (r >= 0) begin a_v = 1; a_rd = r[4:0]; a_d = $urandom; end
            end
            if (m_state != 2 && !q_v && $urandom_range(0, 2) == 0) begin
                r = new_rd();
                if (r >= 0) begin q_v = 1; q_rd = r[4:0]; q_d = $urandom; end
            end
            st_cnt = (m_state == 0) ? 0 : st_cnt + 1;

            issue_valid = 1'($urandom_range(0, 1));
            issue_we    = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rs    = 5'($urandom_range(0, 7));
            issue_rt    = 5'($urandom_range(0, 7));
            halt_req    = (m_state == 0) && ($urandom_range(0, 79) == 0);
            rst         = (m_state == 2 && st_cnt > 4) || st_cnt > 150 ||
                          ($urandom_range(0, 599) == 0);
            alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
            mem_valid = q_v; mem_rd = q_rd; mem_data = q_d;
            #1;

            e_ok = (m_state == 0) && !m_pend[issue_rs] && !m_pend[issue_rt] &&
                   !(issue_we && m_pend[issue_rd]);
            if (m_state == 2) begin
                gq = 0; ga = 0;
            end else if (a_v && q_v) begin
`ifdef WB_ARB_RR_EN
                gq = m_mem_fav;
`else
                gq = 1;
`endif
                ga = !gq;
            end else begin
                gq = q_v; ga = a_v;
            end

            check("rnd issue_ok",  32'(issue_ok),  32'(e_ok));
            check("rnd alu_ready", 32'(alu_ready), 32'(ga));
            check("rnd mem_ready", 32'(mem_ready), 32'(gq));
            check("rnd rd_we",     32'(rd_we),     32'(m_we));
            check("rnd halted",    32'(halted),    32'(m_halted));
            if (m_we) begin
                check("rnd rd_num",  32'(rd_num), 32'(m_num));
                check("rnd rd_data", rd_data,     m_data);
            end
            a_acc = ga; q_acc = gq;

            if (rst) begin
                m_pend = '0; m_state = 0; m_we = 0; m_num = '0; m_data = '0;
                m_halted = 0; m_mem_fav = 1;
            end else begin
                done = (m_pend == 0) && !a_v && !q_v && !m_we;
                if (m_we) m_pend[m_num] = 1'b0;
                if (issue_valid && e_ok && issue_we && issue_rd != 0) m_pend[issue_rd] = 1'b1;
                if (gq) begin
                    m_we = (q_rd != 0); m_num = q_rd; m_data = q_d;
                end else if (ga) begin
                    m_we = (a_rd != 0); m_num = a_rd; m_data = a_d;
                end else begin
                    m_we = 0;
                end
`ifdef WB_ARB_RR_EN
                if (ga || gq) m_mem_fav = ga;
`endif
                if (m_state == 0 && halt_req) m_state = 1;
                else if (m_state == 1 && done) m_state = 2;
                m_halted = (m_state == 2);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
